// File: rtl/wave_sequencer.sv
// Tick-driven waveform sequencer: synchronizes an external divided-clock level,
// advances an 8-bit phase once per tick rise and registers a square/saw/triangle sample.
module wave_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic [7:0] duty,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   step;
    logic [7:0]             phase, phase_next;
    logic [1:0]             active_mode, active_mode_next;
    logic [7:0]             active_duty, active_duty_next;
    logic [7:0]             sample_next;
    logic                   valid_next, wrap_next;

    function automatic logic [7:0] wave(input logic [1:0] m, input logic [7:0] d,
                                        input logic [7:0] p);
        logic [7:0] w;
        case (m)
            2'b00:   w = (p < d) ? 8'hFF : 8'h00;
            2'b01:   w = p;
            2'b10:   w = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: w = ~p;
        endcase
        return w;
    endfunction

    // Last sync stage plus one history flop gives a single-cycle rise detect.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tick};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign step = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= 8'h00;
            active_mode  <= 2'b00;
            active_duty  <= 8'h80;
            sample       <= 8'h00;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            active_mode  <= active_mode_next;
            active_duty  <= active_duty_next;
            sample       <= sample_next;
            sample_valid <= valid_next;
            wrap         <= wrap_next;
        end
    end

    always_comb begin
        state_next       = state;
        phase_next       = phase;
        active_mode_next = active_mode;
        active_duty_next = active_duty;
        sample_next      = sample;
        valid_next       = 1'b0;
        wrap_next        = 1'b0;
        if (step) begin
            valid_next = 1'b1;
            case (state)
                IDLE: begin
                    active_mode_next = mode;
                    active_duty_next = duty;
                    phase_next       = 8'h00;
                    sample_next      = wave(mode, duty, 8'h00);
                    state_next       = RUN;
                end
                default: begin
                    phase_next = phase + 8'd1;
                    // Settings only take effect at a period boundary so a cycle is never torn.
                    if (phase == 8'hFF) begin
                        active_mode_next = mode;
                        active_duty_next = duty;
                        wrap_next        = 1'b1;
                        sample_next      = wave(mode, duty, 8'h00);
                    end else begin
                        sample_next = wave(active_mode, active_duty, phase + 8'd1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: a step model pushes expected samples to a queue,
// a negedge monitor pops and compares whenever sample_valid fires.
module tb_wave_sequencer;

    localparam int S = 2;

    logic       clkin = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [7:0] sample;
    logic       sample_valid;
    logic       wrap;

    wave_sequencer #(.SYNC_STAGES(S)) dut (
        .clkin(clkin), .rst(rst), .tick(tick), .mode(mode), .duty(duty),
        .sample(sample), .sample_valid(sample_valid), .wrap(wrap)
    );

    always #5 clkin = ~clkin;

    typedef struct packed {
        logic [7:0] s;
        logic       w;
    } exp_t;

    exp_t       q[$];
    int         ncmp = 0;
    int         nerr = 0;
    int         nvalid = 0;
    bit         m_run = 1'b0;
    logic [7:0] m_phase = 8'h00;
    logic [1:0] m_mode = 2'b00;
    logic [7:0] m_duty = 8'h80;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_wave(input logic [1:0] m, input logic [7:0] d,
                                            input logic [7:0] p);
        case (m)
            2'b00:   return (p < d) ? 8'hFF : 8'h00;
            2'b01:   return p;
            2'b10:   return p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: return ~p;
        endcase
    endfunction

    // Model one step using the inputs as they stand when the tick rises.
    task automatic push_step();
        exp_t e;
        e.w = 1'b0;
        if (!m_run) begin
            m_run   = 1'b1;
            m_phase = 8'h00;
            m_mode  = mode;
            m_duty  = duty;
        end else begin
            m_phase = m_phase + 8'd1;
            if (m_phase == 8'h00) begin
                m_mode = mode;
                m_duty = duty;
                e.w    = 1'b1;
            end
        end
        e.s = ref_wave(m_mode, m_duty, m_phase);
        q.push_back(e);
    endtask

    always @(negedge clkin) begin
        if (!rst) begin
            if (sample_valid) begin
                nvalid++;
                if (q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sample", sample, e.s);
                    chk("wrap", wrap, e.w);
                end
            end else begin
                chk("wrap_without_valid", wrap, 0);
            end
        end
    end

    task automatic step(input int hi, input int lo);
        push_step();
        tick = 1'b1;
        repeat (hi) @(posedge clkin);
        #1 tick = 1'b0;
        repeat (lo) @(posedge clkin);
        #1;
    endtask

    // Step with the tick held 8 cycles total, reporting latency and the outputs at valid.
    task automatic lat_step(output logic [7:0] s, output logic w);
        int n;
        push_step();
        tick = 1'b1;
        n = 0;
        s = 8'hxx;
        w = 1'bx;
        do begin
            @(posedge clkin);
            #1 n++;
        end while (!sample_valid && n < 20);
        chk("latency", n, S + 1);
        s = sample;
        w = wrap;
        repeat (4 - n) @(posedge clkin);
        #1 tick = 1'b0;
        repeat (4) @(posedge clkin);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clkin);
        chk("drain", q.size(), 0);
        @(posedge clkin);
        #1;
    endtask

    initial begin
        logic [7:0] s;
        logic       w;
        int         n0;

        rst = 1'b1; tick = 1'b0; mode = 2'b01; duty = 8'h00;
        repeat (3) @(posedge clkin);
        #1;
        chk("rst_sample", sample, 8'h00);
        chk("rst_valid", sample_valid, 0);
        chk("rst_wrap", wrap, 0);

        // Tick already high at release: step must not appear before S+1 cycles.
        tick = 1'b1;
        push_step();
        @(posedge clkin);
        #1 rst = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(posedge clkin);
            #1 chk("early_step", sample_valid, 0);
        end
        @(posedge clkin);
        #1 chk("release_valid", sample_valid, 1);
        chk("idle_sample", sample, 8'h00);
        tick = 1'b0;
        repeat (4) @(posedge clkin);
        #1;

        // Saw up at 1/8 rate.
        for (int i = 1; i <= 5; i++) begin
            lat_step(s, w);
            chk("saw_up", s, i);
        end

        // Long tick -> one step.
        n0 = nvalid;
        push_step();
        tick = 1'b1;
        repeat (50) @(posedge clkin);
        #1 tick = 1'b0;
        repeat (6) @(posedge clkin);
        #1 chk("held_once", nvalid - n0, 1);
        chk("held_sample", sample, 8'h06);

        // Mode change mid-period is deferred to the wrap.
        while (m_phase != 8'd100) step(2, 2);
        drain();
        mode = 2'b10;
        while (m_phase != 8'hFF) step(2, 2);
        drain();
        chk("saw_255", sample, 8'hFF);
        lat_step(s, w);
        chk("wrap_sample", s, 8'h00);
        chk("wrap_pulse", w, 1);
        lat_step(s, w);
        chk("tri_p1", s, 8'h02);
        chk("tri_p1_wrap", w, 0);

        // Square: duty 3, then duty 0, then duty 255.
        @(negedge clkin) rst = 1'b1;
        q.delete(); m_run = 1'b0;
        mode = 2'b00; duty = 8'd3;
        @(posedge clkin);
        #1 rst = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        for (int i = 0; i < 4; i++) begin
            lat_step(s, w);
            chk("sq_duty3", s, (i < 3) ? 8'hFF : 8'h00);
        end
        while (m_phase != 8'hFF) step(1, 1);
        drain();
        duty = 8'd0;
        step(1, 1);
        while (m_phase != 8'd128) step(1, 1);
        duty = 8'd255;
        while (m_phase != 8'hFF) step(1, 1);
        drain();
        chk("sq_duty0_255", sample, 8'h00);
        step(1, 1);
        while (m_phase != 8'hFE) step(1, 1);
        drain();
        chk("sq_duty255_254", sample, 8'hFF);
        step(1, 1);
        drain();
        chk("sq_duty255_255", sample, 8'h00);

        // Reset mid-run in saw down.
        @(negedge clkin) rst = 1'b1;
        q.delete(); m_run = 1'b0;
        mode = 2'b11;
        @(posedge clkin);
        #1 rst = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        step(2, 4);
        while (m_phase != 8'd77) step(2, 2);
        drain();
        chk("sawdn_77", sample, 8'hB2);
        @(negedge clkin) rst = 1'b1;
        #1 chk("async_rst_sample", sample, 8'h00);
        q.delete(); m_run = 1'b0;
        @(posedge clkin);
        #1 rst = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        lat_step(s, w);
        chk("post_rst_sample", s, 8'hFF);
        chk("post_rst_wrap", w, 0);

        // Fastest legal tick: one step per two cycles across two wraps.
        n0 = nvalid;
        for (int i = 0; i < 512; i++) step(1, 1);
        drain();
        chk("fast_count", nvalid - n0, 512);
        chk("fast_phase", sample, ref_wave(m_mode, m_duty, m_phase));

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
